// File: rtl/tlp_xcvr_pkg.sv
// Shared TLP transceiver types: action word layout, completion header
// constants and the completion header builder.
package tlp_xcvr_pkg;

   typedef enum logic [1:0] {
      ACT_NOP   = 2'd0,
      ACT_READ  = 2'd1,
      ACT_WRITE = 2'd2
   } ActType;

   localparam int EXT_CHAN_W = 7;
   typedef logic [EXT_CHAN_W-1:0] ExtChan;

   typedef struct packed {
      ActType      typ;
      ExtChan      chan;
      logic [15:0] reqID;
      logic [7:0]  tag;
      logic [31:0] data;
   } Action;

   localparam int ACTION_W = $bits(Action);

   localparam logic [2:0]  FMT_3DW_DATA    = 3'b010;
   localparam logic [4:0]  TYP_CPL         = 5'b01010;
   localparam logic [2:0]  CPL_STATUS_SC   = 3'b000;
   localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEADBEEF;

   typedef struct packed {
      logic [31:0] dw0;
      logic [31:0] dw1;
      logic [31:0] dw2;
   } CplHdr;

   // 3DW completion-with-data header for a one-DW register read.
   // Lower address is the DW-aligned byte address of the channel.
   function automatic CplHdr genCplHeader(
      input logic [12:0] busDev,
      input logic [15:0] reqID,
      input logic [7:0]  tag,
      input ExtChan      chan
   );
      CplHdr  h;
      ExtChan lowerAddr;
      lowerAddr = chan << 2;
      h.dw0 = {FMT_3DW_DATA, TYP_CPL, 24'h000001};
      h.dw1 = {busDev, 3'b000, CPL_STATUS_SC, 1'b0, 12'd4};
      h.dw2 = {reqID, tag, 1'b0, lowerAddr};
      return h;
   endfunction

endpackage

// File: rtl/tlp_action_exec.sv
// Executes actions popped from the TLP receiver action FIFO: register
// writes become a one-cycle strobe, register reads return a completion TLP.
//
// Ports:
//   pcieClk_in, pcieRst_in      clock, synchronous active-high reset
//   cfgBusDev_in                bus/device used for the completer ID
//   actData_in/Valid/actReady   action FIFO pop interface
//   regWr*                      register write strobe, channel, data
//   regRd*                      register read request/ack, channel, data
//   tx*                         64-bit Avalon-ST TX towards the hard IP
module tlp_action_exec
   import tlp_xcvr_pkg::*;
#(
   parameter int RD_TIMEOUT = 255
) (
   input  logic                pcieClk_in,
   input  logic                pcieRst_in,
   input  logic [12:0]         cfgBusDev_in,
   input  logic [ACTION_W-1:0] actData_in,
   input  logic                actValid_in,
   output logic                actReady_out,
   output logic [6:0]          regWrChan_out,
   output logic [31:0]         regWrData_out,
   output logic                regWrValid_out,
   output logic [6:0]          regRdChan_out,
   output logic                regRdReq_out,
   input  logic [31:0]         regRdData_in,
   input  logic                regRdAck_in,
   output logic [63:0]         txData_out,
   output logic                txValid_out,
   input  logic                txReady_in,
   output logic                txSOP_out,
   output logic                txEOP_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_CPL0,
      S_CPL1,
      S_CPL2
   } State;

   localparam logic [15:0] RD_TO = RD_TIMEOUT[15:0];

   State        state;
   logic [15:0] rdCnt;
   logic [15:0] rdCntNext;
   logic [15:0] rdReqID;
   logic [7:0]  rdTag;
   logic [31:0] rdData;
   Action       act;
   CplHdr       hdr;
   logic        pop;
   logic        rdTimeout;
   logic        twoBeat;

   assign actReady_out = (state == S_IDLE) && !pcieRst_in;
   assign pop          = actReady_out && actValid_in;
   assign act          = actData_in;
   assign rdCntNext    = rdCnt + 16'd1;
   assign rdTimeout    = (rdCntNext == RD_TO);

   always_comb begin
      hdr = genCplHeader(cfgBusDev_in, rdReqID, rdTag, regRdChan_out);
   end

   // An odd DW lower address puts the data DW in the same beat as DW2.
   assign twoBeat = hdr.dw2[2];

   always_ff @(posedge pcieClk_in) begin
      if (pcieRst_in) begin
         state          <= S_IDLE;
         rdCnt          <= 16'd0;
         rdReqID        <= 16'd0;
         rdTag          <= 8'd0;
         rdData         <= 32'd0;
         regWrChan_out  <= 7'd0;
         regWrData_out  <= 32'd0;
         regWrValid_out <= 1'b0;
         regRdChan_out  <= 7'd0;
         regRdReq_out   <= 1'b0;
         txData_out     <= 64'd0;
         txValid_out    <= 1'b0;
         txSOP_out      <= 1'b0;
         txEOP_out      <= 1'b0;
      end else begin
         regWrValid_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  unique case (1'b1)
                     (act.typ == ACT_WRITE): begin
                        regWrValid_out <= 1'b1;
                        regWrChan_out  <= act.chan;
                        regWrData_out  <= act.data;
                     end
                     (act.typ == ACT_READ): begin
                        regRdChan_out <= act.chan;
                        rdReqID       <= act.reqID;
                        rdTag         <= act.tag;
                        regRdReq_out  <= 1'b1;
                        rdCnt         <= 16'd0;
                        state         <= S_RD_WAIT;
                     end
                     default: ;
                  endcase
               end
            end
            S_RD_WAIT: begin
               // Ack has priority over a timeout in the same cycle.
               if (regRdAck_in || rdTimeout) begin
                  rdData       <= regRdAck_in ? regRdData_in
                                              : RD_TIMEOUT_DATA;
                  regRdReq_out <= 1'b0;
                  rdCnt        <= 16'd0;
                  txData_out   <= {hdr.dw1, hdr.dw0};
                  txValid_out  <= 1'b1;
                  txSOP_out    <= 1'b1;
                  txEOP_out    <= 1'b0;
                  state        <= S_CPL0;
               end else begin
                  rdCnt <= rdCntNext;
               end
            end
            S_CPL0: begin
               if (txReady_in) begin
                  txSOP_out  <= 1'b0;
                  txData_out <= {twoBeat ? rdData : 32'h0, hdr.dw2};
                  txEOP_out  <= twoBeat;
                  state      <= S_CPL1;
               end
            end
            S_CPL1: begin
               if (txReady_in) begin
                  if (twoBeat) begin
                     txValid_out <= 1'b0;
                     txEOP_out   <= 1'b0;
                     txData_out  <= 64'd0;
                     state       <= S_IDLE;
                  end else begin
                     txData_out <= {32'h0, rdData};
                     txEOP_out  <= 1'b1;
                     state      <= S_CPL2;
                  end
               end
            end
            S_CPL2: begin
               if (txReady_in) begin
                  txValid_out <= 1'b0;
                  txEOP_out   <= 1'b0;
                  txData_out  <= 64'd0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlp_action_exec.sv
// Self-checking bench for tlp_action_exec: directed scenarios plus a
// randomized run against a completion/write reference model.
module tb_tlp_action_exec;
   import tlp_xcvr_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] busDev;
   logic [64:0] actData;
   logic        actValid;
   logic        actReady;
   logic [6:0]  wrChan;
   logic [31:0] wrData;
   logic        wrValid;
   logic [6:0]  rdChan;
   logic        rdReq;
   logic [31:0] rdData;
   logic        rdAck;
   logic [63:0] txData;
   logic        txValid;
   logic        txReady;
   logic        txSOP;
   logic        txEOP;

   always #4 clk = ~clk;

   tlp_action_exec #(.RD_TIMEOUT(TO)) dut (
      .pcieClk_in(clk),
      .pcieRst_in(rst),
      .cfgBusDev_in(busDev),
      .actData_in(actData),
      .actValid_in(actValid),
      .actReady_out(actReady),
      .regWrChan_out(wrChan),
      .regWrData_out(wrData),
      .regWrValid_out(wrValid),
      .regRdChan_out(rdChan),
      .regRdReq_out(rdReq),
      .regRdData_in(rdData),
      .regRdAck_in(rdAck),
      .txData_out(txData),
      .txValid_out(txValid),
      .txReady_in(txReady),
      .txSOP_out(txSOP),
      .txEOP_out(txEOP)
   );

   int nCmp = 0;
   int nFail = 0;
   int reqCnt = 0;
   logic [65:0] txQ[$];
   logic [65:0] expTx[$];
   logic [38:0] wrQ[$];
   logic [38:0] expWr[$];

   // Observed transfers: a handshake seen at the negedge completes
   // at the following posedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (txValid && txReady) txQ.push_back({txSOP, txEOP, txData});
         if (wrValid) wrQ.push_back({wrChan, wrData});
         if (rdReq) reqCnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: sim time exceeded, required finish");
      $fatal(1);
   end

   function automatic logic [64:0] mkAct(input logic [1:0] t,
      input logic [6:0] c, input logic [15:0] r,
      input logic [7:0] g, input logic [31:0] d);
      return {t, c, r, g, d};
   endfunction

   // Reference completion built from the header field rules.
   function automatic void pushCpl(input logic [12:0] bd,
      input logic [6:0] c, input logic [15:0] r,
      input logic [7:0] g, input logic [31:0] d);
      logic [31:0] dw0, dw1, dw2, la;
      dw0 = 32'h4A000001;
      dw1 = 32'(bd) * 32'h80000 + 32'd4;
      la  = (32'(c) % 32) * 4;
      dw2 = 32'(r) * 32'h10000 + 32'(g) * 32'h100 + la;
      expTx.push_back({2'b10, dw1, dw0});
      if (la[2]) begin
         expTx.push_back({2'b01, d, dw2});
      end else begin
         expTx.push_back({2'b00, 32'h0, dw2});
         expTx.push_back({2'b01, 32'h0, d});
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clearQ();
      txQ.delete();
      expTx.delete();
      wrQ.delete();
      expWr.delete();
      reqCnt = 0;
   endtask

   task automatic pushAct(input logic [64:0] a);
      bit popped = 0;
      actData  = a;
      actValid = 1'b1;
      for (int i = 0; i < 100 && !popped; i++) begin
         @(negedge clk);
         popped = actReady;
      end
      nCmp++;
      if (!popped) begin
         nFail++;
         $display("FAIL pop_wait: actReady never 1, required pop");
      end
      cyc();
      actValid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cyc();
      nCmp++;
      if (actReady !== 1'b0) begin
         nFail++;
         $display("FAIL rst_actReady: got %b want 0", actReady);
      end
      nCmp++;
      if ({wrValid, rdReq, txValid, txSOP, txEOP} !== 5'b0) begin
         nFail++;
         $display("FAIL rst_strobes: got %b want 00000",
            {wrValid, rdReq, txValid, txSOP, txEOP});
      end
      nCmp++;
      if ({txData, wrData, wrChan, rdChan} !== 110'd0) begin
         nFail++;
         $display("FAIL rst_data: got %h want 0",
            {txData, wrData, wrChan, rdChan});
      end
      rst = 1'b0;
      cyc();
      nCmp++;
      if (actReady !== 1'b1) begin
         nFail++;
         $display("FAIL idle_actReady: got %b want 1", actReady);
      end
   endtask

   task automatic test_write();
      clearQ();
      pushAct(mkAct(2'd2, 7'd5, 16'h0, 8'h0, 32'h12345678));
      repeat (4) cyc();
      nCmp++;
      if (wrQ.size() !== 1) begin
         nFail++;
         $display("FAIL wr_count: got %0d want 1", wrQ.size());
      end else begin
         nCmp++;
         if (wrQ[0] !== {7'd5, 32'h12345678}) begin
            nFail++;
            $display("FAIL wr_data: got %h want %h",
               wrQ[0], {7'd5, 32'h12345678});
         end
      end
      nCmp++;
      if (txQ.size() !== 0) begin
         nFail++;
         $display("FAIL wr_no_tx: got %0d beats want 0", txQ.size());
      end
   endtask

   task automatic test_read_2beat();
      clearQ();
      busDev = 13'h010;
      pushAct(mkAct(2'd1, 7'd3, 16'h0100, 8'h2A, 32'h0));
      nCmp++;
      if ({rdReq, rdChan} !== {1'b1, 7'd3}) begin
         nFail++;
         $display("FAIL rd_req: got %b/%0d want 1/3", rdReq, rdChan);
      end
      repeat (4) cyc();
      rdData = 32'hCAFEF00D;
      rdAck  = 1'b1;
      cyc();
      rdAck = 1'b0;
      repeat (6) cyc();
      nCmp++;
      if (reqCnt !== 5) begin
         nFail++;
         $display("FAIL rd2_req_cycles: got %0d want 5", reqCnt);
      end
      nCmp++;
      if (txQ.size() !== 2) begin
         nFail++;
         $display("FAIL rd2_beats: got %0d want 2", txQ.size());
      end else begin
         nCmp++;
         if (txQ[0] !== {2'b10, 64'h00800004_4A000001}) begin
            nFail++;
            $display("FAIL rd2_beat0: got %h want %h", txQ[0],
               {2'b10, 64'h00800004_4A000001});
         end
         nCmp++;
         if (txQ[1] !== {2'b01, 64'hCAFEF00D_01002A0C}) begin
            nFail++;
            $display("FAIL rd2_beat1: got %h want %h", txQ[1],
               {2'b01, 64'hCAFEF00D_01002A0C});
         end
      end
   endtask

   task automatic test_read_3beat();
      logic [15:0] r;
      logic [7:0]  g;
      clearQ();
      busDev = 13'($urandom);
      r = 16'($urandom);
      g = 8'($urandom);
      pushAct(mkAct(2'd1, 7'd2, r, g, 32'h0));
      rdData = 32'h55AA55AA;
      rdAck  = 1'b1;
      cyc();
      rdAck = 1'b0;
      nCmp++;
      if ({txValid, txSOP} !== 2'b11) begin
         nFail++;
         $display("FAIL rd3_latency: got v/sop %b want 11",
            {txValid, txSOP});
      end
      pushCpl(busDev, 7'd2, r, g, 32'h55AA55AA);
      repeat (6) cyc();
      nCmp++;
      if (txQ.size() !== expTx.size()) begin
         nFail++;
         $display("FAIL rd3_beats: got %0d want %0d",
            txQ.size(), expTx.size());
      end else begin
         for (int i = 0; i < expTx.size(); i++) begin
            nCmp++;
            if (txQ[i] !== expTx[i]) begin
               nFail++;
               $display("FAIL rd3_beat%0d: got %h want %h",
                  i, txQ[i], expTx[i]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic [6:0]  c;
      logic [31:0] wd;
      bit popped = 0;
      int popAt = -1;
      clearQ();
      c  = 7'($urandom);
      wd = $urandom;
      pushAct(mkAct(2'd1, c, 16'hBEEF, 8'h11, 32'h0));
      actData  = mkAct(2'd2, 7'd9, 16'h0, 8'h0, wd);
      actValid = 1'b1;
      for (int i = 0; i < 80 && !popped; i++) begin
         @(negedge clk);
         if (actReady) begin
            popped = 1;
            popAt  = txQ.size();
         end
      end
      cyc();
      actValid = 1'b0;
      repeat (3) cyc();
      pushCpl(busDev, c, 16'hBEEF, 8'h11, 32'hDEADBEEF);
      nCmp++;
      if (reqCnt !== TO) begin
         nFail++;
         $display("FAIL to_req_cycles: got %0d want %0d", reqCnt, TO);
      end
      nCmp++;
      if (popAt !== expTx.size()) begin
         nFail++;
         $display("FAIL to_pop_after_eop: beats at pop %0d want %0d",
            popAt, expTx.size());
      end
      nCmp++;
      if (txQ.size() !== expTx.size()) begin
         nFail++;
         $display("FAIL to_beats: got %0d want %0d",
            txQ.size(), expTx.size());
      end else begin
         for (int i = 0; i < expTx.size(); i++) begin
            nCmp++;
            if (txQ[i] !== expTx[i]) begin
               nFail++;
               $display("FAIL to_beat%0d: got %h want %h",
                  i, txQ[i], expTx[i]);
            end
         end
      end
      nCmp++;
      if (wrQ.size() !== 1 || wrQ[0] !== {7'd9, wd}) begin
         nFail++;
         $display("FAIL to_queued_wr: got %0d writes want 1 of %h",
            wrQ.size(), {7'd9, wd});
      end
   endtask

   task automatic test_stall();
      logic [63:0] d;
      logic [31:0] v;
      logic        s, e;
      clearQ();
      v = $urandom;
      pushAct(mkAct(2'd1, 7'd3, 16'h1234, 8'h56, 32'h0));
      rdData = v;
      rdAck  = 1'b1;
      cyc();
      rdAck = 1'b0;
      cyc();
      txReady = 1'b0;
      d = txData;
      s = txSOP;
      e = txEOP;
      for (int i = 0; i < 5; i++) begin
         cyc();
         nCmp++;
         if ({txValid, txData, txSOP, txEOP, actReady} !==
             {1'b1, d, s, e, 1'b0}) begin
            nFail++;
            $display("FAIL stall_hold%0d: got %b_%h_%b%b_%b want %b_%h_%b%b_0",
               i, txValid, txData, txSOP, txEOP, actReady,
               1'b1, d, s, e);
         end
      end
      txReady = 1'b1;
      repeat (4) cyc();
      pushCpl(busDev, 7'd3, 16'h1234, 8'h56, v);
      nCmp++;
      if (txQ.size() !== 2) begin
         nFail++;
         $display("FAIL stall_handshakes: got %0d want 2", txQ.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            nCmp++;
            if (txQ[i] !== expTx[i]) begin
               nFail++;
               $display("FAIL stall_beat%0d: got %h want %h",
                  i, txQ[i], expTx[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] wd;
      clearQ();
      wd = $urandom;
      pushAct(mkAct(2'd1, 7'd2, 16'h4321, 8'h77, 32'h0));
      rdData = 32'h0BADF00D;
      rdAck  = 1'b1;
      cyc();
      rdAck = 1'b0;
      cyc();
      txReady = 1'b0;
      rst     = 1'b1;
      cyc();
      nCmp++;
      if ({txValid, rdReq, actReady} !== 3'b000) begin
         nFail++;
         $display("FAIL rstmid_outputs: got %b want 000",
            {txValid, rdReq, actReady});
      end
      rst     = 1'b0;
      txReady = 1'b1;
      repeat (5) cyc();
      nCmp++;
      if (txQ.size() !== 1 || txValid !== 1'b0) begin
         nFail++;
         $display("FAIL rstmid_no_beats: got %0d beats v=%b want 1 v=0",
            txQ.size(), txValid);
      end
      pushAct(mkAct(2'd2, 7'h11, 16'h0, 8'h0, wd));
      repeat (3) cyc();
      nCmp++;
      if (wrQ.size() !== 1 || wrQ[0] !== {7'h11, wd}) begin
         nFail++;
         $display("FAIL rstmid_wr: got %0d writes want 1 of %h",
            wrQ.size(), {7'h11, wd});
      end
   endtask

   task automatic test_random();
      logic [64:0] a;
      logic [64:0] pend;
      bit busy = 0;
      bit rdPhase = 0;
      bit popNow = 0;
      int cnt = 0;
      clearQ();
      busDev = 13'($urandom);
      pend   = '0;
      for (int k = 0; k < 700; k++) begin
         if (!actValid && k < 560 && $urandom_range(1, 0) == 1) begin
            a[31:0]  = $urandom;
            a[63:32] = $urandom;
            a[64]    = 1'($urandom_range(1, 0));
            actData  = a;
            actValid = 1'b1;
         end
         txReady = ($urandom_range(3, 0) != 0);
         rdData  = $urandom;
         rdAck   = rdReq && ($urandom_range(15, 0) == 0);
         @(negedge clk);
         if (actValid && actReady) begin
            popNow = 1;
            nCmp++;
            if (busy) begin
               nFail++;
               $display("FAIL rnd_pop_busy: pop at %0d during completion", k);
            end
            a = actData;
            case (a[64:63])
               2'd2: expWr.push_back({a[62:56], a[31:0]});
               2'd1: begin
                  busy    = 1;
                  rdPhase = 1;
                  pend    = a;
                  cnt     = 0;
               end
               default: ;
            endcase
         end
         if (rdPhase && rdReq) begin
            cnt++;
            if (rdAck) begin
               rdPhase = 0;
               pushCpl(busDev, pend[62:56], pend[55:40], pend[39:32], rdData);
            end else if (cnt == TO) begin
               rdPhase = 0;
               pushCpl(busDev, pend[62:56], pend[55:40], pend[39:32],
                  32'hDEADBEEF);
            end
         end
         if (busy && txValid && txReady && txEOP) busy = 0;
         cyc();
         if (popNow) actValid = 1'b0;
         popNow = 0;
      end
      rdAck = 1'b0;
      nCmp++;
      if (wrQ.size() !== expWr.size()) begin
         nFail++;
         $display("FAIL rnd_wr_count: got %0d want %0d",
            wrQ.size(), expWr.size());
      end else begin
         for (int i = 0; i < expWr.size(); i++) begin
            nCmp++;
            if (wrQ[i] !== expWr[i]) begin
               nFail++;
               $display("FAIL rnd_wr%0d: got %h want %h",
                  i, wrQ[i], expWr[i]);
            end
         end
      end
      nCmp++;
      if (txQ.size() !== expTx.size()) begin
         nFail++;
         $display("FAIL rnd_tx_count: got %0d want %0d",
            txQ.size(), expTx.size());
      end else begin
         for (int i = 0; i < expTx.size(); i++) begin
            nCmp++;
            if (txQ[i] !== expTx[i]) begin
               nFail++;
               $display("FAIL rnd_tx%0d: got %h want %h",
                  i, txQ[i], expTx[i]);
            end
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      busDev   = 13'h0;
      actData  = '0;
      actValid = 1'b0;
      rdData   = 32'h0;
      rdAck    = 1'b0;
      txReady  = 1'b1;
      test_reset();
      test_write();
      test_read_2beat();
      test_read_3beat();
      test_timeout();
      test_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule

// File: doc/tlp_action_exec.md
Name: tlp_action_exec

Overview:
- Sits directly downstream of the TLP receiver's action FIFO. Pops one action at a time and executes it.
- Register writes become a single-cycle write strobe on the register bus.
- Register reads fetch a 32-bit value from the register bus, then emit a 3DW completion-with-data TLP on the 64-bit Avalon-ST TX interface of the PCIe hard IP.
- Owns the read timeout, so a dead register channel can never hang the host.

Parameters:
- RD_TIMEOUT, 255: cycles to wait for regRdAck_in before completing with 32'hDEADBEEF; legal range 1..65535.

Ports:
- pcieClk_in  in  1  125MHz core clock; the only clock.
- pcieRst_in  in  1  reset, synchronous, active-high.
- cfgBusDev_in  in  13  bus[12:5], device[4:0] used for the completer ID; function is fixed at 0.
- actData_in  in  ACTION_W (65)  action word: {typ[1:0], chan[6:0], reqID[15:0], tag[7:0], data[31:0]}.
- actValid_in  in  1  action available.
- actReady_out  out  1  action popped this cycle when actValid_in is also high.
- regWrChan_out  out  7  register write channel.
- regWrData_out  out  32  register write data.
- regWrValid_out  out  1  one-cycle register write strobe.
- regRdChan_out  out  7  register read channel, held while the request is pending.
- regRdReq_out  out  1  read request, level, held until ack or timeout.
- regRdData_in  in  32  read data, valid when regRdAck_in is high.
- regRdAck_in  in  1  read data valid.
- txData_out  out  64  TX beat.
- txValid_out  out  1  TX beat valid.
- txReady_in  in  1  hard IP accepts the beat.
- txSOP_out  out  1  first beat of a TLP.
- txEOP_out  out  1  last beat of a TLP.

Behaviour:
- Reset: state S_IDLE. actReady_out=0 during reset. regWrValid_out, regRdReq_out, txValid_out, txSOP_out and txEOP_out are 0. Data outputs are 0. The timeout counter is 0.
- Reset mid-operation discards any pending read and any partly sent TLP. No further beats are sent; the hard IP's own reset covers recovery.
- Action types:
  - ACT_NOP=0: popped and ignored.
  - ACT_READ=1: register read.
  - ACT_WRITE=2: register write.
  - typ=3 is treated as NOP.
- S_IDLE: actReady_out=1.
  - On actValid_in with WRITE: regWrValid_out=1 next cycle (registered), carrying chan and data. Stay in S_IDLE, so back-to-back writes run at 1 per cycle.
  - On actValid_in with READ: latch chan, reqID and tag; assert regRdReq_out next cycle; go to S_RD_WAIT.
- S_RD_WAIT: actReady_out=0.
  - regRdAck_in in the same cycle as the request is legal and is accepted.
  - On ack: latch regRdData_in, drop the request, go to S_CPL0.
  - The counter increments each cycle without ack. When it reaches RD_TIMEOUT: latch 32'hDEADBEEF, drop the request, go to S_CPL0. Ack and timeout in the same cycle: the ack wins.
- Completion header:
  - DW0 = {3'b010, 5'b01010, 24'h000001}: fmt 3DW with data, type Cpl, TC 0, length 1.
  - DW1 = {cfgBusDev_in, 3'b000, 3'b000 status SC, 1'b0 BCM, 12'd4 byte count}.
  - DW2 = {reqID, tag, 1'b0, lowerAddr}, with lowerAddr = {chan[4:0], 2'b00}.
- Beat layout, chosen from lowerAddr[2]:
  - lowerAddr[2]=1: 2 beats. S_CPL0 sends {DW1, DW0} with SOP. S_CPL1 sends {data, DW2} with EOP.
  - lowerAddr[2]=0: 3 beats. S_CPL0 sends {DW1, DW0} with SOP. S_CPL1 sends {32'h0 pad, DW2}. S_CPL2 sends {32'h0, data} with EOP.
- TX handshake:
  - A beat transfers on txValid_out && txReady_in.
  - While txReady_in=0, every TX output holds stable. txValid_out never drops mid-TLP.
  - After the EOP beat transfers, return to S_IDLE. Completions never interleave.
- Throughput: a read with immediate ack takes 1 cycle in S_IDLE, 1 in S_RD_WAIT, then 2 or 3 beats, before the next action is popped.
- Read latency: actValid_in to the SOP beat on txValid_out is 2 cycles plus the ack wait.

Decomposition:
- Shared package (the existing tlp_xcvr package) holds:
  - the ActType enum and the packed Action struct, with ACTION_W derived from it;
  - the ExtChan width;
  - the constants FMT_3DW_DATA, TYP_CPL, CPL_STATUS_SC and RD_TIMEOUT_DATA (32'hDEADBEEF).
- Single module. No sub-module: the header build is a package function genCplHeader(busDev, reqID, tag, chan), returning DW0, DW1 and DW2.

Test Plan:
- WRITE chan=5, data=32'h12345678 with actValid for 1 cycle -> regWrValid_out=1 for exactly 1 cycle, chan=5, data=12345678. No TX activity.
- READ chan=3 (lowerAddr=0x0C, bit2=1), reqID=0x0100, tag=0x2A, ack with 32'hCAFEF00D after 4 cycles, cfgBusDev=0x010 -> 2 beats:
  - beat 0: {32'h00800004, 32'h4A000001}, SOP=1;
  - beat 1: {32'hCAFEF00D, 32'h01002A0C}, EOP=1.
- READ chan=2 (lowerAddr=0x08), immediate ack with 32'h55AA55AA -> 3 beats:
  - beat 1: {32'h0, DW2};
  - beat 2: {32'h0, 32'h55AA55AA}, EOP=1 only here.
- READ with no ack, RD_TIMEOUT=16 -> regRdReq_out high for exactly 16 cycles, then a completion carrying 32'hDEADBEEF. A WRITE queued behind it pops only after the EOP beat.
- txReady_in held low for 5 cycles on beat 1 of a completion -> txData_out, SOP and EOP are bit-stable across the stall. Exactly 2 handshakes occur. actReady_out stays 0 until EOP.
- pcieRst_in asserted during S_CPL1 -> the next cycle has txValid_out=0 and regRdReq_out=0. After reset, a new WRITE is executed normally.
